// File: rtl/fma_read_buffer.sv
// fma_read_buffer: FIFO of packed lines unpacked into three per-FMA word beats (optional stats via FMA_READ_BUFFER_STATS_EN)
module fma_read_buffer #(
    parameter int FMA_COUNT  = 2,
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WIDTH = 96,
    parameter int DEPTH      = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [LINE_WIDTH-1:0]            line_in,
    input  logic                             line_valid_in,
    output logic                             line_ready_out,
    output logic [WORD_WIDTH*FMA_COUNT-1:0]  word_out,
    output logic                             word_valid_out,
    input  logic                             word_ready_in,
    output logic                             word_last_out,
    output logic                             empty_out
`ifdef FMA_READ_BUFFER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]            lines_done_out,
    output logic [STAT_WIDTH-1:0]            stall_cnt_out
`endif
);
    localparam int BW = WORD_WIDTH * FMA_COUNT;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    typedef enum logic [1:0] {BEAT0, BEAT1, BEAT2} beat_t;
    if (LINE_WIDTH != 3 * WORD_WIDTH * FMA_COUNT) begin : g_bad_width
        $error("LINE_WIDTH must equal 3*WORD_WIDTH*FMA_COUNT");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STAT_WIDTH < 1) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2 and STAT_WIDTH >= 1");
    end
    logic [LINE_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    beat_t beat;
    logic [LINE_WIDTH-1:0] head;
    logic push, xfer, pop;
    // handshake decode and beat slicing of the head line; ready is held low while in reset
    always_comb begin
        line_ready_out = !rst_in && (count != FULL);
        word_valid_out = (count != '0);
        empty_out = (count == '0);
        head = mem[rd_ptr];
        word_out = !word_valid_out ? '0 :
                   (beat == BEAT0) ? head[LINE_WIDTH-1 -: BW] :
                   (beat == BEAT1) ? head[LINE_WIDTH-1-BW -: BW] :
                                     head[LINE_WIDTH-1-2*BW -: BW];
        word_last_out = word_valid_out && (beat == BEAT2);
        push = line_valid_in && line_ready_out;
        xfer = word_valid_out && word_ready_in;
        pop = xfer && (beat == BEAT2);
    end
    // line storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= line_in;
    end
    // pointers, occupancy and beat sequencer over the head line
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            beat <= BEAT0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            count <= (push && !pop) ? count + CNT_ONE : (pop && !push) ? count - CNT_ONE : count;
            if (xfer) beat <= (beat == BEAT0) ? BEAT1 : (beat == BEAT1) ? BEAT2 : BEAT0;
        end
    end
`ifdef FMA_READ_BUFFER_STATS_EN
    localparam logic [STAT_WIDTH-1:0] S_ONE = STAT_WIDTH'(1);
    // saturating counters of drained lines and of producer stall cycles
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lines_done_out <= '0;
            stall_cnt_out <= '0;
        end else begin
            if (pop && lines_done_out != '1) lines_done_out <= lines_done_out + S_ONE;
            if (line_valid_in && !line_ready_out && stall_cnt_out != '1) stall_cnt_out <= stall_cnt_out + S_ONE;
        end
    end
`endif
endmodule
